// File: rtl/accum_stage.sv
// rtl/accum_stage.sv - groups COUNT operands into one sum with sticky carry-out flag
// Optional build macro: ACCUM_SATURATE_EN (clamp the sum to all ones on carry-out instead of wrapping)
module accum_stage #(
  parameter int N     = 4,
  parameter int COUNT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_sum,
  output logic         out_ovf
);

  // A counter of at least one bit keeps COUNT=1 legal.
  localparam int CW = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  state_t        state;
  logic [N-1:0]  acc;
  logic          ovf;
  logic [CW-1:0] cnt;

  logic [N:0]    sum_ext;
  logic          carry;
  logic [N-1:0]  acc_next;

  // Adder with carry-in 0; the extra bit is the carry-out feeding the sticky flag.
  always_comb begin
    sum_ext = {1'b0, acc} + {1'b0, in_data};
    carry   = sum_ext[N];
`ifdef ACCUM_SATURATE_EN
    acc_next = carry ? {N{1'b1}} : sum_ext[N-1:0];
`else
    acc_next = sum_ext[N-1:0];
`endif
  end

  // Group FSM: accumulate COUNT operands, then hold the result until it is consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
      acc   <= '0;
      ovf   <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_valid) begin
            acc <= acc_next;
            ovf <= ovf | carry;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            acc   <= '0;
            ovf   <= 1'b0;
            cnt   <= '0;
            state <= ACCUM;
          end
        end
        default: begin
          state <= ACCUM;
        end
      endcase
    end
  end

  // Handshake flags depend on the state register alone, never on in_valid/out_ready.
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign out_sum   = acc;
  assign out_ovf   = ovf;

endmodule

// File: tb/tb_accum_stage.sv
// tb/tb_accum_stage.sv - self-checking bench for accum_stage (COUNT=4 and COUNT=1 instances)
module tb_accum_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, out_ready;
  logic [3:0] in_data;
  logic       in_ready, out_valid, out_ovf;
  logic [3:0] out_sum;

  logic       in_valid1, out_ready1;
  logic [3:0] in_data1;
  logic       in_ready1, out_valid1, out_ovf1;
  logic [3:0] out_sum1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  accum_stage #(.N(4), .COUNT(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_ovf(out_ovf)
  );

  accum_stage #(.N(4), .COUNT(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_sum(out_sum1), .out_ovf(out_ovf1)
  );

  typedef struct packed {
    logic [3:0][3:0] ops;
    logic [3:0]      exp_sum;
    logic            exp_ovf;
    logic [3:0]      hold;
  } vec_t;

  typedef struct packed {
    logic [3:0] sum;
    logic       ovf;
  } res_t;

  vec_t vecs[5];
  res_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Pop the oldest expected result and compare it with the DUT output now on the bus.
  task automatic pop_cmp(input string name);
    res_t r;
    chk({name, " out_valid"}, out_valid, 1);
    if (sb.size() == 0) begin
      chk({name, " scoreboard nonempty"}, 0, 1);
    end else begin
      r = sb.pop_front();
      chk({name, " out_sum"}, out_sum, r.sum);
      chk({name, " out_ovf"}, out_ovf, r.ovf);
    end
  endtask

  initial begin
    // ops[0] is the first operand sent.
    vecs[0] = '{ops: {4'd4, 4'd3, 4'd2, 4'd1},   exp_sum: 4'd10, exp_ovf: 1'b0, hold: 4'd0};
`ifdef ACCUM_SATURATE_EN
    vecs[1] = '{ops: {4'd0, 4'd0, 4'd1, 4'd15},  exp_sum: 4'd15, exp_ovf: 1'b1, hold: 4'd0};
    vecs[2] = '{ops: {4'd8, 4'd8, 4'd8, 4'd8},   exp_sum: 4'd15, exp_ovf: 1'b1, hold: 4'd0};
    vecs[4] = '{ops: {4'd15, 4'd15, 4'd15, 4'd15}, exp_sum: 4'd15, exp_ovf: 1'b1, hold: 4'd0};
`else
    vecs[1] = '{ops: {4'd0, 4'd0, 4'd1, 4'd15},  exp_sum: 4'd0,  exp_ovf: 1'b1, hold: 4'd0};
    vecs[2] = '{ops: {4'd8, 4'd8, 4'd8, 4'd8},   exp_sum: 4'd0,  exp_ovf: 1'b1, hold: 4'd0};
    vecs[4] = '{ops: {4'd15, 4'd15, 4'd15, 4'd15}, exp_sum: 4'd12, exp_ovf: 1'b1, hold: 4'd0};
`endif
    vecs[3] = '{ops: {4'd2, 4'd0, 4'd0, 4'd3},   exp_sum: 4'd5,  exp_ovf: 1'b0, hold: 4'd5};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    chk("reset in_ready", in_ready, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset out_sum", out_sum, 0);
    chk("reset out_ovf", out_ovf, 0);
    chk("reset dut1 in_ready", in_ready1, 1);

    // Table-driven groups, back-to-back operands.
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("v%0d op%0d in_ready", v, i), in_ready, 1);
        chk($sformatf("v%0d op%0d out_valid", v, i), out_valid, 0);
        in_valid = 1'b1;
        in_data  = vecs[v].ops[i];
        if (i == 3) sb.push_back('{sum: vecs[v].exp_sum, ovf: vecs[v].exp_ovf});
        @(negedge clk);
      end
      in_valid = 1'b0;
      in_data  = 4'd9;
      chk($sformatf("v%0d done in_ready", v), in_ready, 0);
      for (int h = 0; h < int'(vecs[v].hold); h++) begin
        in_valid  = 1'b1;
        in_data   = 4'd7;
        out_ready = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d hold%0d out_valid", v, h), out_valid, 1);
        chk($sformatf("v%0d hold%0d in_ready", v, h), in_ready, 0);
        chk($sformatf("v%0d hold%0d out_sum", v, h), out_sum, vecs[v].exp_sum);
        chk($sformatf("v%0d hold%0d out_ovf", v, h), out_ovf, vecs[v].exp_ovf);
      end
      in_valid = 1'b0;
      pop_cmp($sformatf("v%0d", v));
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk($sformatf("v%0d after in_ready", v), in_ready, 1);
      chk($sformatf("v%0d after out_valid", v), out_valid, 0);
      chk($sformatf("v%0d after cleared sum", v), out_sum, 0);
    end

    // Partial group discarded by reset.
    in_valid = 1'b1; in_data = 4'd5;
    @(negedge clk); @(negedge clk);
    in_valid = 1'b0;
    chk("partial sum", out_sum, 10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst mid sum", out_sum, 0);
    chk("rst mid in_ready", in_ready, 1);
    sb.push_back('{sum: 4'd4, ovf: 1'b0});
    in_valid = 1'b1; in_data = 4'd1;
    for (int i = 0; i < 4; i++) @(negedge clk);
    in_valid = 1'b0;
    pop_cmp("after rst");
    out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;

    // in_valid gaps: 1,0,0,1,0,1,1 with data 2; invalid cycles carry junk data.
    begin
      logic [6:0] pat;
      pat = 7'b1101001;
      sb.push_back('{sum: 4'd8, ovf: 1'b0});
      for (int i = 0; i < 7; i++) begin
        chk($sformatf("gap%0d out_valid", i), out_valid, 0);
        in_valid = pat[i];
        in_data  = pat[i] ? 4'd2 : 4'd13;
        @(negedge clk);
      end
      in_valid = 1'b0;
      pop_cmp("gap");
      out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
    end

    // Reset while a result is pending.
    in_valid = 1'b1; in_data = 4'd3;
    for (int i = 0; i < 4; i++) @(negedge clk);
    in_valid = 1'b0;
    chk("pending out_valid", out_valid, 1);
    rst = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b0;
    chk("rst pending out_valid", out_valid, 0);
    chk("rst pending sum", out_sum, 0);

    // COUNT=1 instance: one result per accepted operand.
    out_ready1 = 1'b1;
    in_valid1 = 1'b1; in_data1 = 4'd9;
    @(negedge clk);
    in_valid1 = 1'b0;
    chk("c1 first in_ready", in_ready1, 0);
    chk("c1 first out_valid", out_valid1, 1);
    chk("c1 first sum", out_sum1, 9);
    chk("c1 first ovf", out_ovf1, 0);
    in_valid1 = 1'b1; in_data1 = 4'd3;
    @(negedge clk);
    chk("c1 back in_ready", in_ready1, 1);
    chk("c1 back out_valid", out_valid1, 0);
    @(negedge clk);
    in_valid1 = 1'b0;
    chk("c1 second in_ready", in_ready1, 0);
    chk("c1 second sum", out_sum1, 3);
    @(negedge clk);
    chk("c1 final in_ready", in_ready1, 1);
    out_ready1 = 1'b0;

    chk("scoreboard drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
